// File: rtl/vga_grid_addr_gen_pkg.sv
// Shared grid geometry for the VGA pixel-to-grid mapping path.
// These constants are the parameter defaults of the grid address generator
// and its per-axis cell counter.
package vga_grid_addr_gen_pkg;

    // Cell edge length in pixels.
    localparam int DEF_CELL_PX     = 8;
    // Grid size in cells, 640x480 with 8-pixel cells.
    localparam int DEF_GRID_COLS   = 80;
    localparam int DEF_GRID_ROWS   = 60;
    // Width of a linear cell address, enough for GRID_COLS*GRID_ROWS cells.
    localparam int DEF_GRID_ADDR_W = 13;

endpackage

// File: rtl/vga_grid_addr_gen_cell_cnt.sv
// Single-axis cell counter: tracks the cell index and the pixel offset
// inside the cell along one screen axis.
// start restarts the axis at cell 0, offset 0. step advances by one pixel
// or line while active. start has priority over step.
module vga_cell_cnt
    import vga_grid_addr_gen_pkg::*;
#(
    parameter int CELL_PX = DEF_CELL_PX,
    parameter int N_CELLS = DEF_GRID_COLS,
    parameter int IDX_W   = 8,
    parameter int SUB_W   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             step,
    output logic [IDX_W-1:0] idx,
    output logic [SUB_W-1:0] sub,
    output logic             act,
    output logic             wrap
);

    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(CELL_PX - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_CELLS - 1);

    // A cell boundary is crossed on this step; a simultaneous restart wins.
    assign wrap = step & ~start & act & (sub == SUB_LAST);

    // Cell/offset counter: restart on start, count while active, and
    // deactivate (clearing the counters) after the last pixel of the last cell.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act <= 1'b0;
            sub <= '0;
            idx <= '0;
        end else if (start) begin
            act <= 1'b1;
            sub <= '0;
            idx <= '0;
        end else if (step && act) begin
            if (sub == SUB_LAST) begin
                sub <= '0;
                if (idx == IDX_LAST) begin
                    idx <= '0;
                    act <= 1'b0;
                end else begin
                    idx <= idx + IDX_W'(1);
                end
            end else begin
                sub <= sub + SUB_W'(1);
            end
        end
    end

endmodule

// File: rtl/vga_grid_addr_gen.sv
// Pixel-to-grid address generator for the VGA path.
// Maps the timing generator's (hcount, vcount) onto grid cell indices,
// cell-local offsets, a cell-edge flag and a linear RAM address using
// incremental per-axis counters (no multiply, no divide). Output latency is
// two pix_ce beats; de/hsync/vsync are delayed to match.
//
// Beat semantics: pix_ce is a qualifier, not a handshake. A clk edge with
// pix_ce high consumes the pixel on the inputs and advances every register
// by one stage; with pix_ce low every register holds. The pixel sampled on
// beat N appears on the outputs after beat N+1.
module vga_grid_addr_gen
    import vga_grid_addr_gen_pkg::*;
#(
    parameter int H_W       = 10,
    parameter int V_W       = 10,
    parameter int CELL_PX   = DEF_CELL_PX,
    parameter int GRID_COLS = DEF_GRID_COLS,
    parameter int GRID_ROWS = DEF_GRID_ROWS,
    parameter int ORIGIN_X  = 0,
    parameter int ORIGIN_Y  = 0,
    parameter int GX_W      = 8,
    parameter int GY_W      = 7,
    parameter int SUB_W     = 3,
    parameter int ADDR_W    = DEF_GRID_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pix_ce,
    input  logic              de,
    input  logic              hsync,
    input  logic              vsync,
    input  logic [H_W-1:0]    hcount,
    input  logic [V_W-1:0]    vcount,
    output logic [GX_W-1:0]   gx,
    output logic [GY_W-1:0]   gy,
    output logic [SUB_W-1:0]  sub_x,
    output logic [SUB_W-1:0]  sub_y,
    output logic [ADDR_W-1:0] addr,
    output logic              in_grid,
    output logic              cell_edge,
    output logic              de_o,
    output logic              hsync_o,
    output logic              vsync_o
);

    localparam logic [GY_W-1:0] GY_LAST = GY_W'(GRID_ROWS - 1);

    // Stage 1: axis counters and the sync/DE first delay stage
    logic [GX_W-1:0]   x_idx;
    logic [GY_W-1:0]   y_idx;
    logic [SUB_W-1:0]  x_sub;
    logic [SUB_W-1:0]  y_sub;
    logic              x_act;
    logic              y_act;
    logic              y_wrap;
    logic              unused_x_wrap;
    logic [ADDR_W-1:0] row_base;
    logic              de_d1;
    logic              hsync_d1;
    logic              vsync_d1;

    logic y_step;
    logic y_start;
    logic y_last;
    logic y_act_nxt;
    logic x_start;
    logic in_grid_d1;

    // The Y axis moves once per line, on the beat carrying hcount==0.
    assign y_step    = pix_ce & (hcount == '0);
    assign y_start   = y_step & (vcount == V_W'(ORIGIN_Y));
    assign y_last    = y_wrap & (y_idx == GY_LAST);
    // Y activity after this beat, so an origin column of 0 can start X on
    // the same beat that starts Y.
    assign y_act_nxt = y_start | (y_act & ~y_last);
    assign x_start   = pix_ce & (hcount == H_W'(ORIGIN_X)) & y_act_nxt;

    vga_cell_cnt #(
        .CELL_PX (CELL_PX),
        .N_CELLS (GRID_COLS),
        .IDX_W   (GX_W),
        .SUB_W   (SUB_W)
    ) u_x_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .start (x_start),
        .step  (pix_ce),
        .idx   (x_idx),
        .sub   (x_sub),
        .act   (x_act),
        .wrap  (unused_x_wrap)
    );

    vga_cell_cnt #(
        .CELL_PX (CELL_PX),
        .N_CELLS (GRID_ROWS),
        .IDX_W   (GY_W),
        .SUB_W   (SUB_W)
    ) u_y_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .start (y_start),
        .step  (y_step),
        .idx   (y_idx),
        .sub   (y_sub),
        .act   (y_act),
        .wrap  (y_wrap)
    );

    // Row base address: cleared at the origin line and after the last row,
    // advanced by one grid row whenever the Y axis enters a new cell row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_base <= '0;
        end else if (y_start) begin
            row_base <= '0;
        end else if (y_wrap) begin
            row_base <= y_last ? '0 : row_base + ADDR_W'(GRID_COLS);
        end
    end

    // First delay stage for DE and syncs, aligned with the counter stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_d1    <= 1'b0;
            hsync_d1 <= 1'b0;
            vsync_d1 <= 1'b0;
        end else if (pix_ce) begin
            de_d1    <= de;
            hsync_d1 <= hsync;
            vsync_d1 <= vsync;
        end
    end

    assign in_grid_d1 = de_d1 & x_act & y_act;

    // Stage 2: output register; all grid fields are forced to 0 outside
    // the visible grid so downstream logic never sees stale indices.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gx        <= '0;
            gy        <= '0;
            sub_x     <= '0;
            sub_y     <= '0;
            addr      <= '0;
            in_grid   <= 1'b0;
            cell_edge <= 1'b0;
            de_o      <= 1'b0;
            hsync_o   <= 1'b0;
            vsync_o   <= 1'b0;
        end else if (pix_ce) begin
            in_grid   <= in_grid_d1;
            gx        <= in_grid_d1 ? x_idx : '0;
            gy        <= in_grid_d1 ? y_idx : '0;
            sub_x     <= in_grid_d1 ? x_sub : '0;
            sub_y     <= in_grid_d1 ? y_sub : '0;
            addr      <= in_grid_d1 ? row_base + ADDR_W'(x_idx) : '0;
            cell_edge <= in_grid_d1 & ((x_sub == '0) | (y_sub == '0));
            de_o      <= de_d1;
            hsync_o   <= hsync_d1;
            vsync_o   <= vsync_d1;
        end
    end

endmodule
